// File: rtl/plot_framebuffer_scanout.sv
// plot_framebuffer_scanout
// Accepts single-pixel plot writes into a 160x120 x 3-bit framebuffer and
// scans it out as 640x480@60 VGA, each stored pixel shown as a 4x4 block.
// Optional build macro FB_CLEAR_ON_RESET_EN: after reset, sweep the whole
// framebuffer to BG_COLOUR (ready low) before accepting plot writes.
module plot_framebuffer_scanout #(
  parameter int         FB_W      = 160,
  parameter int         FB_H      = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       ready,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n
);

  localparam int          DEPTH   = FB_W * FB_H;
  localparam logic [14:0] DEPTH_L = 15'(DEPTH);
  localparam logic [7:0]  FB_W_L  = 8'(FB_W);
  localparam logic [6:0]  FB_H_L  = 7'(FB_H);

  logic [2:0]  mem [0:DEPTH-1];

  logic        pix_en_r;
  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic        hs_s, vs_s, vis_s;
  logic        hs_d_r, vs_d_r, vis_d_r;
  logic [2:0]  rdata_r;
  logic [14:0] rd_row_s, rd_col_s, raddr_s;
  logic [14:0] wr_row_s, wr_col_s, wr_addr_s;
  logic        in_range_s;
  logic        we_s;
  logic [14:0] waddr_s;
  logic [2:0]  wdata_s;

`ifdef FB_CLEAR_ON_RESET_EN
  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;
  state_t      state_r, next_s;
  logic [14:0] clr_cnt_r;

  // Clear-sweep state and address counter; reset restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= CLEAR;
      clr_cnt_r <= 15'd0;
    end else begin
      state_r <= next_s;
      if (state_r == CLEAR) begin
        clr_cnt_r <= clr_cnt_r + 15'd1;
      end else begin
        clr_cnt_r <= 15'd0;
      end
    end
  end

  // Leave CLEAR once the last framebuffer address has been written.
  always_comb begin
    next_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_cnt_r == DEPTH_L - 15'd1) begin
          next_s = RUN;
        end else begin
          next_s = CLEAR;
        end
      end
      RUN:     next_s = RUN;
      default: next_s = CLEAR;
    endcase
  end

  assign ready = (state_r == RUN);
`else
  assign ready = 1'b1;
`endif

  // Pixel-clock enable and raster counters; both counters step on pix_en.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_en_r <= 1'b0;
      h_cnt_r  <= 10'd0;
      v_cnt_r  <= 10'd0;
    end else begin
      pix_en_r <= ~pix_en_r;
      if (pix_en_r) begin
        if (h_cnt_r == 10'd799) begin
          h_cnt_r <= 10'd0;
          if (v_cnt_r == 10'd524) begin
            v_cnt_r <= 10'd0;
          end else begin
            v_cnt_r <= v_cnt_r + 10'd1;
          end
        end else begin
          h_cnt_r <= h_cnt_r + 10'd1;
        end
      end
    end
  end

  // Sync/visible decode and address arithmetic (row*160 as row*128 + row*32).
  always_comb begin
    hs_s       = !((h_cnt_r >= 10'd656) && (h_cnt_r <= 10'd751));
    vs_s       = !((v_cnt_r >= 10'd490) && (v_cnt_r <= 10'd491));
    vis_s      = (h_cnt_r < 10'd640) && (v_cnt_r < 10'd480);
    rd_row_s   = {7'd0, v_cnt_r[9:2]};
    rd_col_s   = {7'd0, h_cnt_r[9:2]};
    raddr_s    = (rd_row_s << 4'd7) + (rd_row_s << 4'd5) + rd_col_s;
    wr_row_s   = {8'd0, y};
    wr_col_s   = {7'd0, x};
    wr_addr_s  = (wr_row_s << 4'd7) + (wr_row_s << 4'd5) + wr_col_s;
    in_range_s = (x < FB_W_L) && (y < FB_H_L);
  end

  // Select the RAM write source: clear sweep or an accepted in-range plot.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = wr_addr_s;
    wdata_s = colour;
`ifdef FB_CLEAR_ON_RESET_EN
    if (state_r == CLEAR) begin
      we_s    = resetn;
      waddr_s = clr_cnt_r;
      wdata_s = BG_COLOUR;
    end else begin
      we_s = plot && resetn && in_range_s;
    end
`else
    if (plot && ready && resetn && in_range_s) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
`endif
  end

  // Framebuffer write port; a same-cycle read of that address sees old data.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[waddr_s] <= wdata_s;
    end
  end

  // Stage 1: synchronous RAM read alongside delayed sync/visible flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_r <= 3'b000;
      hs_d_r  <= 1'b1;
      vs_d_r  <= 1'b1;
      vis_d_r <= 1'b0;
    end else begin
      rdata_r <= (raddr_s < DEPTH_L) ? mem[raddr_s] : 3'b000;
      hs_d_r  <= hs_s;
      vs_d_r  <= vs_s;
      vis_d_r <= vis_s;
    end
  end

  // Stage 2: registered VGA outputs, colour forced to black while blanked.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 1'b0;
      vga_g       <= 1'b0;
      vga_b       <= 1'b0;
    end else begin
      vga_hs      <= hs_d_r;
      vga_vs      <= vs_d_r;
      vga_blank_n <= vis_d_r;
      vga_r       <= vis_d_r & rdata_r[2];
      vga_g       <= vis_d_r & rdata_r[1];
      vga_b       <= vis_d_r & rdata_r[0];
    end
  end

endmodule

// File: tb/tb_plot_framebuffer_scanout.sv
// Directed testbench for plot_framebuffer_scanout.
// Output for counter tick t (t = v*800 + h) is observed 2t+2 and 2t+3
// posedges after reset release, counting the first edge with resetn=1 as 1.
module tb_plot_framebuffer_scanout;

  logic       clk;
  logic       resetn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       ready;
  logic       vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n;

  int checks = 0;
  int fails  = 0;

`ifdef FB_CLEAR_ON_RESET_EN
  localparam logic [2:0] BG = 3'b001;
`else
  localparam logic [2:0] BG = 3'b000;
`endif

  // Reference image of pixel rows 0..5, columns 0..47.
  logic [2:0] model [0:5][0:47];

  plot_framebuffer_scanout #(
    .FB_W(160), .FB_H(120), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .ready(ready), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    plot   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b} !== 6'b110000) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 110000", i,
                 {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b});
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_hsync();
    int fall1 = -1, rise1 = -1, fall2 = -1;
    int blank_hi = 0, vs_low = 0, rgb_blank = 0;
    logic prev_hs = 1'b1;
    for (int i = 1; i <= 3200; i++) begin
      tick();
      if (prev_hs && !vga_hs) begin
        if (fall1 < 0) fall1 = i;
        else if (fall2 < 0) fall2 = i;
      end
      if (!prev_hs && vga_hs && rise1 < 0) rise1 = i;
      prev_hs = vga_hs;
      if (i <= 1600 && vga_blank_n) blank_hi++;
      if (!vga_vs) vs_low++;
      if (!vga_blank_n && {vga_r, vga_g, vga_b} != 3'b000) rgb_blank++;
    end
    checks++;
    if (fall1 != 1314) begin
      fails++; $display("FAIL hs_first_fall: got %0d expected 1314", fall1);
    end
    checks++;
    if (rise1 - fall1 != 192) begin
      fails++; $display("FAIL hs_low_width: got %0d expected 192", rise1 - fall1);
    end
    checks++;
    if (fall2 - fall1 != 1600) begin
      fails++; $display("FAIL hs_period: got %0d expected 1600", fall2 - fall1);
    end
    checks++;
    if (blank_hi != 1280) begin
      fails++; $display("FAIL blank_n_line_width: got %0d expected 1280", blank_hi);
    end
    checks++;
    if (vs_low != 0) begin
      fails++; $display("FAIL vs_early_frame: got %0d low samples expected 0", vs_low);
    end
    checks++;
    if (rgb_blank != 0) begin
      fails++; $display("FAIL rgb_in_blank: got %0d lit samples expected 0", rgb_blank);
    end
  endtask

  // Writes go out back to back: plot stays high across consecutive calls.
  task automatic put_px(input int px, input int py, input logic [2:0] c);
    x = 8'(px); y = 7'(py); colour = c; plot = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b1) begin
      fails++; $display("FAIL ready_run: got %b expected 1", ready);
    end
    if (px < 48 && py < 6) model[py][px] = c;
  endtask

  task automatic test_plot();
    for (int yy = 0; yy < 6; yy++)
      for (int xx = 0; xx < 48; xx++) model[yy][xx] = 3'b000;
    for (int yy = 0; yy < 6; yy++)
      for (int xx = 0; xx < 48; xx++) put_px(xx, yy, 3'b000);
    put_px(5, 3, 3'b101);
    plot = 1'b0;
    tick();
  endtask

  task automatic test_out_of_range();
    // Model untouched: these must not land anywhere.
    x = 8'd160; y = 7'd1;   colour = 3'b111; plot = 1'b1; tick();
    x = 8'd10;  y = 7'd120; tick();
    x = 8'd200; y = 7'd0;   tick();
    x = 8'd255; y = 7'd127; tick();
    plot = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int yy = 2; yy < 6; yy++)
      for (int xx = 40; xx < 44; xx++) put_px(xx, yy, 3'b010);
    plot = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset_scan();
    int t, h, v;
    logic [2:0] exp_c;
    // Reset mid-line with a plot in the same cycle: the plot must be lost.
    resetn = 1'b0;
    x = 8'd1; y = 7'd0; colour = 3'b111; plot = 1'b1;
    tick();
    plot = 1'b0;
    checks++;
    if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b} !== 6'b110000) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b expected 110000",
               {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b});
    end
    tick();
    resetn = 1'b1;
    for (int i = 1; i <= 2 * (24 * 800) + 1; i++) begin
      tick();
      if (i >= 2 && (i % 2) == 0) begin
        t = (i - 2) / 2;
        h = t % 800;
        v = t / 800;
        if (h < 192) begin
          exp_c = model[v / 4][h / 4];
          checks++;
          if ({vga_r, vga_g, vga_b} !== exp_c) begin
            fails++;
            $display("FAIL pixel h=%0d v=%0d: got %b expected %b", h, v,
                     {vga_r, vga_g, vga_b}, exp_c);
          end
        end else if (h >= 640) begin
          checks++;
          if ({vga_blank_n, vga_r, vga_g, vga_b} !== 4'b0000) begin
            fails++;
            $display("FAIL hblank h=%0d v=%0d: got %b expected 0000", h, v,
                     {vga_blank_n, vga_r, vga_g, vga_b});
          end
        end
      end
    end
  endtask

`ifdef FB_CLEAR_ON_RESET_EN
  task automatic test_clear();
    int n = 0;
    int t, h;
    resetn = 1'b0;
    plot   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    while (ready !== 1'b1 && n < 20000) begin
      if (n == 10000) begin
        x = 8'd0; y = 7'd3; colour = 3'b111; plot = 1'b1;
      end else begin
        plot = 1'b0;
      end
      tick();
      n++;
    end
    plot = 1'b0;
    checks++;
    if (n != 19200) begin
      fails++; $display("FAIL clear_ready_delay: got %0d expected 19200", n);
    end
    // Lines v=12,13 (pixel row 3, holding the dropped plot) must be all BG.
    for (int i = n + 1; i <= 2 * (13 * 800 + 799) + 3; i++) begin
      tick();
      if ((i % 2) == 0) begin
        t = (i - 2) / 2;
        h = t % 800;
        if (h < 640) begin
          checks++;
          if ({vga_r, vga_g, vga_b} !== BG) begin
            fails++;
            $display("FAIL clear_pixel h=%0d v=%0d: got %b expected %b", h,
                     t / 800, {vga_r, vga_g, vga_b}, BG);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    x = 8'd0; y = 7'd0; colour = 3'b000; plot = 1'b0;
    test_reset();
    test_hsync();
`ifdef FB_CLEAR_ON_RESET_EN
    test_clear();
`else
    test_plot();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset_scan();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/plot_framebuffer_scanout.md
Name: plot_framebuffer_scanout

Overview:
- Receiving end of the pixel-plot interface (x, y, colour, plot) driven by the square drawers and game-logic FSMs.
- Stores plotted pixels in an on-chip 160x120 x 3-bit framebuffer.
- Continuously scans the framebuffer out as 640x480@60 VGA, replicating each stored pixel into a 4x4 block.
- Sits between all drawing FSMs and the board's VGA DAC pins.

Parameters:
- FB_W, 160: framebuffer width in pixels; x is 8 bits.
- FB_H, 120: framebuffer height in pixels; y is 7 bits.
- BG_COLOUR, 3'b000: colour written by the clear sweep (optional feature).

Ports:
- clk  in  1  50 MHz system clock.
- resetn  in  1  Synchronous, active-low reset.
- x  in  8  Plot column, 0..FB_W-1.
- y  in  7  Plot row, 0..FB_H-1.
- colour  in  3  Plot colour {R,G,B}.
- plot  in  1  Write strobe; one pixel is written per clk while high and accepted.
- ready  out  1  High when plot writes are accepted.
- vga_r, vga_g, vga_b  out  1 each  Colour out; forced to 0 while blanked.
- vga_hs  out  1  Horizontal sync, active low.
- vga_vs  out  1  Vertical sync, active low.
- vga_blank_n  out  1  High in the visible region.

Behaviour:
- Pixel enable pix_en toggles every clk (25 MHz). It is 0 in the first cycle after reset.
- h_cnt runs 0..799 and v_cnt runs 0..524. Both advance only when pix_en=1. h_cnt wraps 799->0; v_cnt increments on that wrap and wraps 524->0.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Read address = (v_cnt>>2)*160 + (h_cnt>>2). Compute it as (row<<7)+(row<<5)+col, 15 bits.
- RAM is 19200 x 3 with a synchronous read (1 clk).
- hs, vs and blank are pipelined so that all outputs for counter value (h,v) register together, exactly 2 clk after the counters hold (h,v).
- Outputs are registered. Each VGA pixel is therefore held for 2 clk.
- Write path: when plot && ready && x<FB_W && y<FB_H, the RAM at y*160+x is written with colour on that clk edge.
- Out-of-range coordinates are silently dropped. There is no wrap and no partial write.
- Write and read of the same address in the same clk: the read returns the old data. The new value is visible from the next read.
- Back-to-back plot every clk, e.g. 16 consecutive writes from a 4x4 square, is fully supported with no stalls.
- Reset values:
  - h_cnt=0, v_cnt=0, pix_en=0.
  - vga_hs=1, vga_vs=1, vga_blank_n=0, vga_r/g/b=0.
  - Pipeline registers are cleared.
- RAM contents are not affected by reset unless the optional feature is enabled.
- Reset asserted mid-frame: counters return to 0 on the next edge. A plot in the same cycle as resetn=0 is discarded.
- Without the optional feature, ready=1 in every cycle where resetn=1.

Optional Feature:
- Macro FB_CLEAR_ON_RESET_EN.
- When defined, a CLEAR state is entered on reset. A 15-bit clear counter sweeps addresses 0..19199, writing BG_COLOUR at one address per clk. ready=0 throughout the sweep.
- After address 19199 is written, the block enters RUN and ready=1 from the following clk.
- plot is ignored in CLEAR. Scan-out runs normally during CLEAR.
- Reset during CLEAR restarts the sweep from 0.
- When not defined, there is no CLEAR state and the RAM contents at power-up are undefined or from initialisation.

Test Plan:
1. Hold resetn=0 for 4 clk, then release. During reset: hs=1, vs=1, blank_n=0, rgb=0. Afterwards, the first hs low pulse spans 96 pix_en ticks (192 clk) and starts 656 ticks after h_cnt=0; hs period is 1600 clk.
2. Run a full frame. vs is low for exactly 2 lines (3200 clk) per 525-line frame (840000 clk). blank_n is high for exactly 640x480 pixels.
3. plot=1 with x=5, y=3, colour=3'b101 for one clk. In the next frame, rgb=101 for h 20..23 and v 12..15, and the neighbouring pixels are unchanged.
4. plot with x=160, y=10 and with x=10, y=120, colour=3'b111. No RAM location changes; a full-frame scan shows no new 111 pixels.
5. 16 consecutive plot cycles forming a 4x4 square at (40,40), colour 3'b010. A 16x16 block of 010 appears at VGA h 160..175, v 160..175.
6. With FB_CLEAR_ON_RESET_EN and BG_COLOUR=3'b001, release reset. ready=0 for 19200 clk, then 1. A plot during the sweep is dropped. The following frame is entirely 001.
